pipe_elastic_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_skid_slice.sv | 81 ++++++++
 rtl/pipe_elastic_reg.sv | 75 +++++++
 tb/tb_pipe_elastic_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the elastic pipeline register
package pipe_pkg;

  localparam int PIPE_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Counter width able to hold 0 .. 2*depth entries.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_slice.sv
// rtl/pipe_skid_slice.sv - one elastic stage: main register plus skid entry, registered ready
module pipe_skid_slice
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             validIn,
  output logic             readyIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             validOut,
  input  logic             readyOut
);

  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_valid;
  logic             skid_valid;
  logic             in_fire;
  logic             out_fire;
  stage_state_e     state;

  // Ready depends only on the skid flop, so back-pressure never ripples combinationally upstream.
  assign readyIn  = !skid_valid;
  assign dataOut  = main_data;
  assign validOut = main_valid;
  assign in_fire  = validIn && !skid_valid;
  assign out_fire = main_valid && readyOut;

  always_comb begin
    state = EMPTY;
    if (main_valid && skid_valid) begin
      state = FULL;
    end else if (main_valid) begin
      state = BUSY;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data  <= dataIn;
            main_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data <= dataIn;
          end else if (in_fire) begin
            skid_data  <= dataIn;
            skid_valid <= 1'b1;
          end else if (out_fire) begin
            main_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_elastic_reg.sv
// rtl/pipe_elastic_reg.sv - DEPTH chained skid slices with flush; PIPE_OCCUPANCY_EN adds an occupancy count
module pipe_elastic_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT,
  parameter int DEPTH = 1
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             dataIn,
  input  logic                         validIn,
  output logic                         readyIn,
  output logic [WIDTH-1:0]             dataOut,
  output logic                         validOut,
  input  logic                         readyOut
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0]  occupancy
`endif
);

  logic [DEPTH:0][WIDTH-1:0] stage_data;
  logic [DEPTH:0]            stage_valid;
  logic [DEPTH:0]            stage_ready;

  assign stage_data[0]      = dataIn;
  assign stage_valid[0]     = validIn;
  assign stage_ready[DEPTH] = readyOut;
  assign dataOut            = stage_data[DEPTH];
  assign validOut           = stage_valid[DEPTH];
  // Slices come out of reset ready, so hold off upstream until reset is released.
  assign readyIn            = RSTn && stage_ready[0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_skid_slice #(
      .WIDTH(WIDTH)
    ) u_slice (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .flush   (flush),
      .dataIn  (stage_data[i]),
      .validIn (stage_valid[i]),
      .readyIn (stage_ready[i]),
      .dataOut (stage_data[i+1]),
      .validOut(stage_valid[i+1]),
      .readyOut(stage_ready[i+1])
    );
  end

`ifdef PIPE_OCCUPANCY_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_q;
  logic             occ_in;
  logic             occ_out;

  assign occ_in    = validIn && readyIn;
  assign occ_out   = validOut && readyOut;
  assign occupancy = occ_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (occ_in && !occ_out) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (occ_out && !occ_in) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// tb/tb_pipe_elastic_reg.sv - directed self-checking bench for pipe_elastic_reg (DEPTH=2)
module tb_pipe_elastic_reg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             flush;
  logic [WIDTH-1:0] dataIn;
  logic             validIn;
  logic             readyIn;
  logic [WIDTH-1:0] dataOut;
  logic             validOut;
  logic             readyOut;
`ifdef PIPE_OCCUPANCY_EN
  logic [$clog2(2*DEPTH+1)-1:0] occupancy;
`endif

  int checks = 0;
  int errors = 0;

  pipe_elastic_reg #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .flush   (flush),
    .dataIn  (dataIn),
    .validIn (validIn),
    .readyIn (readyIn),
    .dataOut (dataOut),
    .validOut(validOut),
    .readyOut(readyOut)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    int          accepts;
    logic        in_acc;
    logic        out_acc;

    RSTn     = 1'b0;
    flush    = 1'b0;
    validIn  = 1'b1;
    dataIn   = 32'hDEAD_BEEF;
    readyOut = 1'b1;

    // Reset with a pending input
    #1;
    chk("rst_ready_pre", readyIn, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", validOut, 0);
      chk("rst_data", dataOut, 0);
      chk("rst_ready", readyIn, 0);
    end
    RSTn    = 1'b1;
    validIn = 1'b0;
    tick();
    chk("rel_ready", readyIn, 1);
    chk("rel_valid", validOut, 0);

    // Streaming 1..8 back-to-back
    readyOut = 1'b1;
    for (int c = 0; c < 11; c++) begin
      validIn = (c < 8);
      dataIn  = 32'(c + 1);
      if (c < 8) chk("stream_ready", readyIn, 1);
      tick();
      if (c >= 1 && c <= 8) begin
        chk("stream_valid", validOut, 1);
        chk("stream_data", dataOut, 32'(c));
      end else begin
        chk("stream_idle", validOut, 0);
      end
    end

    // Back-pressure fill
    readyOut = 1'b0;
    accepts  = 0;
    for (int c = 0; c < 8; c++) begin
      validIn = 1'b1;
      dataIn  = 32'hA0 + 32'(accepts);
      if (readyIn) accepts++;
      tick();
    end
    chk("bp_accepts", accepts, 4);
    chk("bp_ready_low", readyIn, 0);
    chk("bp_head", dataOut, 32'hA0);
`ifdef PIPE_OCCUPANCY_EN
    chk("bp_occ", occupancy, 4);
`endif

    // Stalled output must not move
    validIn = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stab_valid", validOut, 1);
      chk("stab_data", dataOut, 32'hA0);
    end

    // Drain after back-pressure
    readyOut = 1'b1;
    tick();
    chk("bp_d1_data", dataOut, 32'hA1);
    chk("bp_d1_ready", readyIn, 0);
    tick();
    chk("bp_d2_data", dataOut, 32'hA2);
    chk("bp_d2_ready", readyIn, 1);
    tick();
    chk("bp_d3_data", dataOut, 32'hA3);
    chk("bp_d3_valid", validOut, 1);
    tick();
    chk("bp_d4_valid", validOut, 0);

    // Flush with concurrent input and output
    readyOut = 1'b0;
    for (int c = 0; c < 3; c++) begin
      validIn = 1'b1;
      dataIn  = 32'h11 * 32'(c + 1);
      chk("fl_fill_ready", readyIn, 1);
      tick();
    end
    chk("fl_head_valid", validOut, 1);
    chk("fl_head_data", dataOut, 32'h11);
    flush    = 1'b1;
    validIn  = 1'b1;
    dataIn   = 32'h44;
    readyOut = 1'b1;
    tick();
    flush   = 1'b0;
    validIn = 1'b0;
    chk("fl_valid_after", validOut, 0);
    chk("fl_ready_after", readyIn, 1);
`ifdef PIPE_OCCUPANCY_EN
    chk("fl_occ", occupancy, 0);
`endif
    tick();
    tick();
    chk("fl_no_leak", validOut, 0);

    // Random traffic against a queue model
    readyOut = 1'b0;
    validIn  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      in_acc  = validIn && readyIn;
      out_acc = validOut && readyOut;
      if (out_acc) begin
        if (q.size() == 0) chk("rand_underflow", 1, 0);
        else chk("rand_data", dataOut, q.pop_front());
      end
      if (in_acc) q.push_back(dataIn);
      tick();
`ifdef PIPE_OCCUPANCY_EN
      chk("rand_occ", occupancy, 32'(q.size()));
`endif
      readyOut = 1'($urandom_range(0, 1));
      if (!(validIn && !in_acc)) begin
        validIn = 1'($urandom_range(0, 1));
        dataIn  = $urandom;
      end
    end
    validIn  = 1'b0;
    readyOut = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (validOut) begin
        if (q.size() == 0) chk("drain_underflow", 1, 0);
        else chk("drain_data", dataOut, q.pop_front());
      end
      tick();
    end
    chk("drain_empty", 32'(q.size()), 0);
    chk("drain_valid", validOut, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
